seq_div_i12_o12: RTL and testbench
==================================

// Module: seq_div_i12_o12
// PURPOSE
//   Sequential restoring divider: 12-bit unsigned dividend / 6-bit unsigned divisor -> 12-bit quotient, 6-bit remainder.
//   Inverse of the i12_o12 6x6 multiplier family: a product bus {g0..g5 x g6..g11} can be divided back by one operand.
//   Serves as the round-trip checker in multiplier error evaluation. One quotient bit per cycle; valid/ready at both ends.
// PARAMETERS
//   DW    12  dividend and quotient width
//   VW    6   divisor and remainder width
//   CW    4   iteration counter width; CW >= $clog2(DW+1)
// PORTS
//   clk        in   1   clock, all state updates on rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   operands valid
//   in_ready   out  1   block accepts operands (high only in IDLE)
//   dividend   in   DW  unsigned dividend
//   divisor    in   VW  unsigned divisor
//   out_valid  out  1   result valid; held until out_ready
//   out_ready  in   1   consumer accepts result
//   quotient   out  DW  floor(dividend/divisor)
//   remainder  out  VW  dividend mod divisor
//   div_zero   out  1   divisor was 0 (present only with SEQ_DIV_DZ_FLAG_EN)
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, counter=0.
//   - Reset overrides everything, including a mid-division BUSY or a pending DONE; that result is dropped.
//   - FSM: IDLE -> BUSY on in_valid&in_ready (divisor!=0); IDLE -> DONE on accept with divisor==0;
//     BUSY -> DONE when counter reaches DW; DONE -> IDLE on out_valid&out_ready.
//   - Accept: latch dividend into shift reg Q, divisor into D, partial remainder R (VW+1 bits) = 0, counter = 0.
//   - BUSY iteration: {R,Q} <<= 1; T = R - {1'b0,D}; if T >= 0 then R=T, Q[0]=1 else Q[0]=0; counter++.
//   - Latency: accept at edge N -> out_valid high after edge N+DW+1 (13 cycles default). Divisor 0: after edge N+1.
//   - Divisor 0: quotient = {DW{1'b1}}, remainder = {VW{1'b1}}; no iterations performed.
//   - out_valid/quotient/remainder stable while out_valid & !out_ready; no operand accepted in BUSY or DONE.
//   - Result handshake and next operand are never same-cycle: in_ready rises the cycle after out handshake.
//   - in_valid may drop without acceptance; inputs ignored when in_ready=0. dividend=0 -> quotient 0, remainder 0.
//   - R never exceeds VW+1 bits; final remainder = R[VW-1:0] (guaranteed < D).
// CONFIGURATION
//   SEQ_DIV_DZ_FLAG_EN defined: div_zero port exists; set with out_valid when divisor was 0, cleared on out handshake.
//   Not defined: no div_zero port; divisor 0 still yields all-ones quotient/remainder with same latency.
// STRUCTURE
//   Package seq_div_pkg: state enum (S_IDLE, S_BUSY, S_DONE), DW/VW defaults, DIV0_QUOT/DIV0_REM constants.
//   Sub-module div_step: combinational single restoring step (R,Q,D in -> R',Q' out); FSM/regs stay in top.
// TESTING
//   1. 4095 / 63 -> quotient 65, remainder 0, out_valid exactly 13 cycles after accept.
//   2. 1000 / 7 -> quotient 142, remainder 6; 0 / 5 -> quotient 0, remainder 0.
//   3. 300 / 0 -> quotient 4095, remainder 63, div_zero=1 (with _EN), out_valid 1 cycle after accept.
//   4. out_ready held low 5 cycles after result -> outputs stable, in_ready=0, in_valid pulses ignored.
//   5. rst asserted at iteration 6 -> next cycle in_ready=1, out_valid=0; fresh 81/9 -> 9 rem 0.
//   6. Exhaustive round-trip: all a,b in 1..63, dividend=a*b, divisor=b -> quotient a, remainder 0.

Source files
------------

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and constants for the sequential restoring divider.
package seq_div_pkg;
    localparam int DW_DEF = 12;
    localparam int VW_DEF = 6;
    localparam int CW_DEF = 4;
    localparam logic [DW_DEF-1:0] DIV0_QUOT = '1;
    localparam logic [VW_DEF-1:0] DIV0_REM = '1;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on {R,Q}.
module div_step #(
    parameter int DW = 12,
    parameter int VW = 6
) (
    input  logic [VW:0]   r,
    input  logic [DW-1:0] q,
    input  logic [VW-1:0] d,
    output logic [VW:0]   r_next,
    output logic [DW-1:0] q_next
);
    logic [VW+1:0] sh;
    logic [VW+2:0] t;
    always_comb begin
        sh = {r, q[DW-1]};
        // an extra top bit acts as the borrow/sign of the trial subtraction
        t = {1'b0, sh} - {3'b000, d};
        r_next = t[VW+2] ? sh[VW:0] : t[VW:0];
        q_next = {q[DW-2:0], ~t[VW+2]};
    end
endmodule

// File: rtl/seq_div_i12_o12.sv
// seq_div_i12_o12: sequential unsigned divider, one quotient bit per cycle, valid/ready at both ends.
// Define SEQ_DIV_DZ_FLAG_EN to expose the div_zero output flag.
module seq_div_i12_o12
    import seq_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
`ifdef SEQ_DIV_DZ_FLAG_EN
    ,
    output logic          div_zero
`endif
);
    state_t state;
    logic [VW:0] r, r_next;
    logic [DW-1:0] q, q_next;
    logic [VW-1:0] d;
    logic [CW-1:0] cnt;

    div_step #(.DW(DW), .VW(VW)) u_step (
        .r(r), .q(q), .d(d), .r_next(r_next), .q_next(q_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            quotient <= '0;
            remainder <= '0;
            cnt <= '0;
            r <= '0;
            q <= '0;
            d <= '0;
`ifdef SEQ_DIV_DZ_FLAG_EN
            div_zero <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    q <= dividend;
                    d <= divisor;
                    r <= '0;
                    cnt <= '0;
                    in_ready <= 1'b0;
                    state <= (divisor == '0) ? S_DONE : S_BUSY;
                end
                S_BUSY: if (cnt == CW'(DW)) begin
                    state <= S_DONE;
                    out_valid <= 1'b1;
                    quotient <= q;
                    remainder <= r[VW-1:0];
                end else begin
                    r <= r_next;
                    q <= q_next;
                    cnt <= cnt + 1'b1;
                end
                // only a zero divisor reaches DONE with out_valid still low
                S_DONE: if (!out_valid) begin
                    out_valid <= 1'b1;
                    quotient <= DIV0_QUOT;
                    remainder <= DIV0_REM;
`ifdef SEQ_DIV_DZ_FLAG_EN
                    div_zero <= 1'b1;
`endif
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                    state <= S_IDLE;
`ifdef SEQ_DIV_DZ_FLAG_EN
                    div_zero <= 1'b0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div_i12_o12.sv
// tb_seq_div_i12_o12: table vectors, scoreboard queue and corner sequences for seq_div_i12_o12.
module tb_seq_div_i12_o12;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [11:0] dividend = '0;
    logic [5:0] divisor = '0;
    logic in_ready, out_valid;
    logic [11:0] quotient;
    logic [5:0] remainder;
`ifdef SEQ_DIV_DZ_FLAG_EN
    logic div_zero;
`endif

    seq_div_i12_o12 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder)
`ifdef SEQ_DIV_DZ_FLAG_EN
        , .div_zero(div_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [5:0]  b;
        logic [11:0] q;
        logic [5:0]  r;
    } vec_t;

    typedef struct {
        logic [11:0] q;
        logic [5:0]  r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic accept(input logic [11:0] a, input logic [5:0] b, input logic [11:0] eq, input logic [5:0] er);
        int k;
        exp_t e;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        dividend = a;
        divisor = b;
        in_valid = 1'b1;
        @(posedge clk);
        e.q = eq;
        e.r = er;
        e.dz = (b == 6'd0);
        e.lat = (b == 6'd0) ? 1 : 13;
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic await_result(input string nm);
        int k;
        exp_t e;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({nm, "_latency"}, k, e.lat);
            chk({nm, "_quotient"}, int'(quotient), int'(e.q));
            chk({nm, "_remainder"}, int'(remainder), int'(e.r));
            chk({nm, "_in_ready_busy"}, int'(in_ready), 0);
`ifdef SEQ_DIV_DZ_FLAG_EN
            chk({nm, "_div_zero"}, int'(div_zero), int'(e.dz));
`endif
        end
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_out_valid_clr"}, int'(out_valid), 0);
        chk({nm, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    vec_t vecs[10];
    logic [11:0] hq;
    logic [5:0] hr;

    initial begin
        vecs[0] = '{a: 12'd4095, b: 6'd63, q: 12'd65,   r: 6'd0};
        vecs[1] = '{a: 12'd1000, b: 6'd7,  q: 12'd142,  r: 6'd6};
        vecs[2] = '{a: 12'd0,    b: 6'd5,  q: 12'd0,    r: 6'd0};
        vecs[3] = '{a: 12'd300,  b: 6'd0,  q: 12'd4095, r: 6'd63};
        vecs[4] = '{a: 12'd4095, b: 6'd1,  q: 12'd4095, r: 6'd0};
        vecs[5] = '{a: 12'd63,   b: 6'd63, q: 12'd1,    r: 6'd0};
        vecs[6] = '{a: 12'd5,    b: 6'd6,  q: 12'd0,    r: 6'd5};
        vecs[7] = '{a: 12'd2047, b: 6'd2,  q: 12'd1023, r: 6'd1};
        vecs[8] = '{a: 12'd4000, b: 6'd37, q: 12'd108,  r: 6'd4};
        vecs[9] = '{a: 12'd0,    b: 6'd0,  q: 12'd4095, r: 6'd63};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
`ifdef SEQ_DIV_DZ_FLAG_EN
        chk("reset_div_zero", int'(div_zero), 0);
`endif

        for (int i = 0; i < 10; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
            await_result($sformatf("vec%0d", i));
            handshake($sformatf("vec%0d", i));
        end

        // result held under backpressure; operand pulses must be ignored
        accept(12'd1234, 6'd11, 12'd112, 6'd2);
        await_result("stall");
        hq = quotient;
        hr = remainder;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 12'($urandom_range(0, 4095));
            divisor = 6'($urandom_range(1, 63));
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_quotient", int'(quotient), int'(hq));
            chk("stall_remainder", int'(remainder), int'(hr));
            chk("stall_in_ready", int'(in_ready), 0);
        end
        handshake("stall");
        accept(12'd100, 6'd10, 12'd10, 6'd0);
        await_result("post_stall");
        handshake("post_stall");

        // reset mid-division drops the pending result
        accept(12'd1000, 6'd7, 12'd142, 6'd6);
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        accept(12'd81, 6'd9, 12'd9, 6'd0);
        await_result("midrst_81_9");
        handshake("midrst_81_9");

        for (int b = 1; b < 64; b++) begin
            for (int a = 1; a < 64; a++) begin
                accept(12'(a * b), 6'(b), 12'(a), 6'd0);
                await_result($sformatf("rt_%0dx%0d", a, b));
                handshake("rt");
            end
        end

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
